// File: rtl/ms_countdown.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ms_countdown : synchronises clk_1ms into ms_tick and runs a loadable     |
// |                millisecond countdown timer with tick-loss watchdog.      |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module ms_countdown #(
    parameter int WIDTH       = 16,
    parameter bit AUTO_RELOAD = 1'b0,
    parameter int LOST_LIMIT  = 60000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_1ms,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    output logic             ms_tick,
    output logic [WIDTH-1:0] remaining,
    output logic             running,
    output logic             done,
    output logic             expired,
    output logic             tick_lost
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] c_lost_limit = 16'(LOST_LIMIT);

    logic             s1_q, s2_q, s3_q;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expired_q, expired_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic [15:0]      gap_q, gap_d;
    logic             tick_lost_q, tick_lost_d;
    logic             w_tick;

    // s1 is the metastability stage; the edge is detected on s2/s3 only.
    assign w_tick = s2_q & ~s3_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        reload_d    = reload_q;
        expired_d   = 1'b0;

        if (load) begin
            remaining_d = load_val;
            reload_d    = load_val;
            state_d     = S_IDLE;
        end else if (stop && state_q == S_RUN) begin
            state_d = S_PAUSE;
        end else if (start && (state_q == S_IDLE || state_q == S_PAUSE)
                     && remaining_q != '0) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN && w_tick) begin
            if (remaining_q > WIDTH'(1)) begin
                remaining_d = remaining_q - WIDTH'(1);
            end else begin
                expired_d = 1'b1;
                if (AUTO_RELOAD && reload_q != '0) begin
                    remaining_d = reload_q;
                end else begin
                    remaining_d = '0;
                    state_d     = S_DONE;
                end
            end
        end

        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_comb begin
        if (w_tick) begin
            gap_d = '0;
        end else if (gap_q == c_lost_limit) begin
            gap_d = gap_q;
        end else begin
            gap_d = gap_q + 16'd1;
        end
        tick_lost_d = (gap_d == c_lost_limit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            state_q     <= S_IDLE;
            remaining_q <= '0;
            reload_q    <= '0;
            expired_q   <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            gap_q       <= '0;
            tick_lost_q <= 1'b0;
        end else begin
            s1_q        <= clk_1ms;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            reload_q    <= reload_d;
            expired_q   <= expired_d;
            running_q   <= running_d;
            done_q      <= done_d;
            gap_q       <= gap_d;
            tick_lost_q <= tick_lost_d;
        end
    end

    assign ms_tick   = w_tick;
    assign remaining = remaining_q;
    assign running   = running_q;
    assign done      = done_q;
    assign expired   = expired_q;
    assign tick_lost = tick_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_ms_countdown.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ms_countdown : self-checking bench for ms_countdown (one-shot and     |
// |                   auto-reload instances driven from the same stimulus).  |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_ms_countdown;

    localparam int W   = 16;
    localparam int LIM = 100;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic         clk = 1'b0, rst_n = 1'b0, clk_1ms = 1'b0;
    logic         load = 1'b0, start = 1'b0, stop = 1'b0;
    logic [W-1:0] load_val = '0;

    logic         tick0, run0, done0, exp0, lost0;
    logic [W-1:0] rem0;
    logic         tick1, run1, done1, exp1, lost1;
    logic [W-1:0] rem1;

    ms_countdown #(.WIDTH(W), .AUTO_RELOAD(1'b0), .LOST_LIMIT(LIM)) dut0 (
        .clk(clk), .rst_n(rst_n), .clk_1ms(clk_1ms), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .ms_tick(tick0), .remaining(rem0), .running(run0),
        .done(done0), .expired(exp0), .tick_lost(lost0));

    ms_countdown #(.WIDTH(W), .AUTO_RELOAD(1'b1), .LOST_LIMIT(LIM)) dut1 (
        .clk(clk), .rst_n(rst_n), .clk_1ms(clk_1ms), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .ms_tick(tick1), .remaining(rem1), .running(run1),
        .done(done1), .expired(exp1), .tick_lost(lost1));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: sample history of clk_1ms, mode and count per timer.
    bit h[3];
    int m_rem[2], m_rl[2], m_st[2], m_exp[2];
    int m_gap;
    bit gen_en = 1'b1;
    int ph = 0;
    bit last_applied = 1'b0;
    int since_tick = 1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_tick_now();
        return h[1] & ~h[2];
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            m_rem[a] = 0; m_rl[a] = 0; m_st[a] = M_IDLE; m_exp[a] = 0;
        end
        h[0] = 1'b0; h[1] = 1'b0; h[2] = 1'b0;
        m_gap = 0;
    endtask

    task automatic model_step(input bit ld, input int val, input bit st, input bit sp);
        bit t;
        t = m_tick_now();
        for (int a = 0; a < 2; a++) begin
            m_exp[a] = 0;
            if (ld) begin
                m_rem[a] = val; m_rl[a] = val; m_st[a] = M_IDLE;
            end else if (sp && m_st[a] == M_RUN) begin
                m_st[a] = M_PAUSE;
            end else if (st && (m_st[a] == M_IDLE || m_st[a] == M_PAUSE) && m_rem[a] != 0) begin
                m_st[a] = M_RUN;
            end else if (m_st[a] == M_RUN && t) begin
                m_rem[a] = m_rem[a] - 1;
                if (m_rem[a] == 0) begin
                    m_exp[a] = 1;
                    if (a == 1 && m_rl[a] != 0) m_rem[a] = m_rl[a];
                    else m_st[a] = M_DONE;
                end
            end
        end
        m_gap = t ? 0 : ((m_gap < LIM) ? m_gap + 1 : LIM);
        h[2] = h[1]; h[1] = h[0]; h[0] = clk_1ms;
    endtask

    task automatic compare_all();
        check("ms_tick0",   tick0, m_tick_now());
        check("ms_tick1",   tick1, m_tick_now());
        check("remaining0", rem0,  m_rem[0]);
        check("remaining1", rem1,  m_rem[1]);
        check("running0",   run0,  m_st[0] == M_RUN);
        check("running1",   run1,  m_st[1] == M_RUN);
        check("done0",      done0, m_st[0] == M_DONE);
        check("done1",      done1, m_st[1] == M_DONE);
        check("expired0",   exp0,  m_exp[0]);
        check("expired1",   exp1,  m_exp[1]);
        check("tick_lost0", lost0, m_gap == LIM);
        check("tick_lost1", lost1, m_gap == LIM);
    endtask

    task automatic cyc(input bit ld, input int val, input bit st, input bit sp);
        @(negedge clk);
        last_applied = m_tick_now();
        load = ld; load_val = W'(val); start = st; stop = sp;
        clk_1ms = gen_en && (ph < 10);
        ph = (ph + 1) % 20;
        model_step(ld, val, st, sp);
        @(posedge clk);
        #1;
        compare_all();
        since_tick = m_tick_now() ? 0 : since_tick + 1;
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        int guard = 0;
        while (c < n && guard < 200) begin
            cyc(0, 0, 0, 0);
            if (last_applied) c++;
            guard++;
        end
        if (c < n) check("tick_timeout", c, n);
    endtask

    task automatic wait_tick_present();
        int guard = 0;
        while (!m_tick_now() && guard < 200) begin
            cyc(0, 0, 0, 0);
            guard++;
        end
        if (!m_tick_now()) check("tick_present_timeout", 0, 1);
    endtask

    typedef struct {
        bit ld; int val; bit st; bit sp; int nt;
        int rem; bit run; bit dn;
    } vec_t;

    vec_t tbl[9];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        int lost_at;

        tbl[0] = '{1, 3, 0, 0, 0, 3, 0, 0};
        tbl[1] = '{0, 0, 1, 0, 0, 3, 1, 0};
        tbl[2] = '{0, 0, 0, 0, 1, 2, 1, 0};
        tbl[3] = '{0, 0, 0, 0, 1, 1, 1, 0};
        tbl[4] = '{0, 0, 0, 0, 1, 0, 0, 1};
        tbl[5] = '{0, 0, 0, 0, 2, 0, 0, 1};
        tbl[6] = '{1, 5, 0, 0, 0, 5, 0, 0};
        tbl[7] = '{0, 0, 1, 0, 0, 5, 1, 0};
        tbl[8] = '{0, 0, 0, 0, 2, 3, 1, 0};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // First tick two edges after the first high sample, then 20-cycle period
        cyc(0, 0, 0, 0);
        check("first_tick_early", tick0, 0);
        cyc(0, 0, 0, 0);
        check("first_tick", tick0, 1);
        n = 0;
        do begin
            cyc(0, 0, 0, 0);
            n++;
        end while (!tick0 && n < 40);
        check("tick_period", n, 20);

        // One-shot countdown and the start of the pause scenario
        foreach (tbl[i]) begin
            if (tbl[i].ld || tbl[i].st || tbl[i].sp)
                cyc(tbl[i].ld, tbl[i].val, tbl[i].st, tbl[i].sp);
            wait_ticks(tbl[i].nt);
            check($sformatf("tbl%0d_rem", i),  rem0,  tbl[i].rem);
            check($sformatf("tbl%0d_run", i),  run0,  tbl[i].run);
            check($sformatf("tbl%0d_done", i), done0, tbl[i].dn);
        end

        // Stop colliding with a tick: the tick is dropped
        wait_tick_present();
        cyc(0, 0, 0, 1);
        check("pause_rem", rem0, 3);
        check("pause_run", run0, 0);
        wait_ticks(3);
        check("pause_hold_rem", rem0, 3);
        cyc(0, 0, 1, 0);
        check("resume_run", run0, 1);
        wait_ticks(2);
        check("resume_rem1", rem0, 1);
        wait_ticks(1);
        check("resume_rem0", rem0, 0);
        check("resume_expired", exp0, 1);
        check("resume_done", done0, 1);
        cyc(0, 0, 0, 0);
        check("expired_one_cycle", exp0, 0);

        // Auto-reload instance
        cyc(1, 2, 0, 0);
        cyc(0, 0, 1, 0);
        check("ar_rem_start", rem1, 2);
        for (int k = 1; k <= 4; k++) begin
            wait_ticks(1);
            check("ar_rem", rem1, (k % 2 == 1) ? 1 : 2);
            check("ar_expired", exp1, (k % 2 == 0) ? 1 : 0);
            check("ar_done", done1, 0);
            check("ar_running", run1, 1);
        end
        cyc(1, 7, 1, 0);
        check("ar_load_start_rem", rem1, 7);
        check("ar_load_start_run", run1, 0);

        // Tick source stalls, then resumes
        gen_en = 1'b0;
        lost_at = -1;
        for (int i = 0; i < 150; i++) begin
            cyc(0, 0, 0, 0);
            if (lost0 && lost_at < 0) lost_at = since_tick;
        end
        check("lost_at", lost_at, LIM + 1);
        check("lost_held", lost0, 1);
        gen_en = 1'b1;
        wait_tick_present();
        check("lost_on_tick", lost0, 1);
        cyc(0, 0, 0, 0);
        check("lost_cleared", lost0, 0);

        // Asynchronous reset in the middle of a run
        cyc(1, 4, 0, 0);
        cyc(0, 0, 1, 0);
        check("pre_reset_rem", rem0, 4);
        check("pre_reset_run", run0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rem0", rem0, 0);
        check("rst_run0", run0, 0);
        check("rst_rem1", rem1, 0);
        check("rst_run1", run1, 0);
        check("rst_tick", tick0, 0);
        check("rst_lost", lost0, 0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        cyc(0, 0, 1, 0);
        check("post_reset_start_ignored", run0, 0);
        check("post_reset_rem", rem0, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 99);
            gen_en = !(i >= 300 && i < 430);
            cyc(r < 5, $urandom_range(0, 6), (r >= 5 && r < 20), (r >= 20 && r < 28));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
